// File: rtl/ex_hilo_muldiv_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit.
// Op encodings, FSM state encoding and small op-decode helpers.
package ex_hilo_muldiv_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_hilo_muldiv_iter_datapath.sv
// Iterative shift-add multiply / restoring divide datapath with sign fix-up.
// The accumulator holds {HI-half, LO-half}; the operand register holds |B|.
module muldiv_iter_datapath
    import ex_hilo_muldiv_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         Clk,
    input  logic         load,
    input  logic         step,
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo,
    output logic         div_by_zero
);

    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opnd_q;
    logic [W-1:0]   a_orig_q;
    logic           sign_a_q;
    logic           sign_b_q;
    op_e            op_q;
    logic           dbz_q;

    logic           neg_a;
    logic           neg_b;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic [W:0]     div_diff;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    assign neg_a = op_is_signed(op) & a[W-1];
    assign neg_b = op_is_signed(op) & b[W-1];
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    // Multiply: add |B| into the upper half when the current LSB is set, then shift right.
    // Divide: shift {R,Q} left, trial-subtract |B|, keep the difference if no borrow.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff = rem_sh - {1'b0, opnd_q};
        if (op_is_div(op_q)) begin
            if (div_diff[W])
                acc_next = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
            else
                acc_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc_q[W-1:1]};
        end
    end

    always_ff @(posedge Clk) begin
        if (load) begin
            acc_q    <= {{W{1'b0}}, mag_a};
            opnd_q   <= mag_b;
            a_orig_q <= a;
            sign_a_q <= neg_a;
            sign_b_q <= neg_b;
            op_q     <= op;
            dbz_q    <= op_is_div(op) && (b == {W{1'b0}});
        end else if (step) begin
            acc_q <= acc_next;
        end
    end

    // Remainder follows the dividend's sign (truncating division).
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = sign_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        if (!op_is_div(op_q)) begin
            res_hi = prod_fix[2*W-1:W];
            res_lo = prod_fix[W-1:0];
        end else if (dbz_q) begin
            res_hi = a_orig_q;
            res_lo = {W{1'b1}};
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    assign div_by_zero = dbz_q;

endmodule

// File: rtl/ex_hilo_muldiv.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Handshake: Start is taken only in IDLE (and not with Flush); Busy/Done are level/pulse status, no back-pressure.
module ex_hilo_muldiv
    import ex_hilo_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = ex_hilo_muldiv_pkg::DATA_WIDTH,
    parameter int ITERATIONS = DATA_WIDTH
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  WriteHi,
    input  logic                  WriteLo,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] Hi,
    output logic [DATA_WIDTH-1:0] Lo
);

    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    state_e                state_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  dbz_q;

    logic                  load;
    logic                  step;
    logic [DATA_WIDTH-1:0] res_hi;
    logic [DATA_WIDTH-1:0] res_lo;
    logic                  dp_dbz;

    assign load = (state_q == ST_IDLE) && Start && !Flush;
    assign step = (state_q == ST_RUN) && !Flush;

    muldiv_iter_datapath #(
        .W(DATA_WIDTH)
    ) u_datapath (
        .Clk         (Clk),
        .load        (load),
        .step        (step),
        .op          (op_e'(Op)),
        .a           (A),
        .b           (B),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (dp_dbz)
    );

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        state_q <= ST_RUN;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        if (WriteHi) hi_q <= WriteData;
                        if (WriteLo) lo_q <= WriteData;
                    end
                end
                ST_RUN: begin
                    if (Flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        count_q <= count_q + 1'b1;
                        if (count_q == CW'(ITERATIONS - 1)) begin
                            state_q <= ST_FIX;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dbz_q   <= dp_dbz;
                        end
                    end
                end
                ST_FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    state_q <= ST_IDLE;
                    count_q <= '0;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    dbz_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Self-checking bench for ex_hilo_muldiv: directed and random ops through a scoreboard queue.
// Expected {DivByZero, Hi, Lo} are pushed at launch and popped once HI/LO commit.
module tb_ex_hilo_muldiv;

    localparam int DW = 32;
    localparam int EW = 2 * DW + 1;

    logic          Clk = 1'b0;
    logic          ResetN;
    logic          Start;
    logic [1:0]    Op;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          WriteHi;
    logic          WriteLo;
    logic [DW-1:0] WriteData;
    logic          Flush;
    logic          Busy;
    logic          Done;
    logic          DivByZero;
    logic [DW-1:0] Hi;
    logic [DW-1:0] Lo;

    logic [EW-1:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;

    ex_hilo_muldiv dut (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .WriteHi   (WriteHi),
        .WriteLo   (WriteLo),
        .WriteData (WriteData),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (Done) done_cnt++;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: begin p = sa * sb; return {1'b0, p}; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                q = sa / sb; r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    task automatic idle_inputs();
        Start = 0; Op = 0; A = 0; B = 0;
        WriteHi = 0; WriteLo = 0; WriteData = 0; Flush = 0;
    endtask

    task automatic do_reset();
        ResetN = 0;
        repeat (3) @(negedge Clk);
        ResetN = 1;
        @(negedge Clk);
    endtask

    task automatic write_hilo(input logic wh, input logic wl, input logic [DW-1:0] d);
        WriteHi = wh; WriteLo = wl; WriteData = d;
        @(negedge Clk);
        WriteHi = 0; WriteLo = 0;
    endtask

    // Runs one op from a negedge; optionally flushes during FIX (which must still commit).
    task automatic run_op(input string tag, input logic [1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [EW-1:0] exp, input bit flush_in_fix);
        int busy_cycles = 0;
        int cycles = 0;
        int d0;
        logic [EW-1:0] e;
        logic dbz;
        exp_q.push_back(exp);
        d0 = done_cnt;
        Start = 1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 0;
        while (!Done && cycles < 40) begin
            if (Busy) busy_cycles++;
            cycles++;
            @(negedge Clk);
        end
        e = exp_q.pop_front();
        check({tag, " done_seen"}, EW'(Done), EW'(1));
        if (Done) begin
            check({tag, " busy_cycles"}, EW'(busy_cycles), EW'(32));
            check({tag, " busy_in_fix"}, EW'(Busy), EW'(0));
            dbz = DivByZero;
            if (flush_in_fix) Flush = 1;
            @(negedge Clk);
            Flush = 0;
            #1;
            check({tag, " dbz"}, EW'(dbz), EW'(e[EW-1]));
            check({tag, " hi"}, EW'(Hi), EW'(e[2*DW-1:DW]));
            check({tag, " lo"}, EW'(Lo), EW'(e[DW-1:0]));
            check({tag, " done_once"}, EW'(done_cnt - d0), EW'(1));
            check({tag, " done_low"}, EW'(Done), EW'(0));
        end
    endtask

    task automatic abort_test(input string tag, input bit use_reset, input logic [EW-1:0] exp_after);
        int d0;
        write_hilo(1, 1, 32'hAAAA0000);
        d0 = done_cnt;
        Start = 1; Op = 2'b00; A = 32'd1234; B = 32'd5678;
        @(negedge Clk);
        Start = 0;
        repeat (9) @(negedge Clk);
        if (use_reset) ResetN = 0; else Flush = 1;
        @(negedge Clk);
        ResetN = 1; Flush = 0;
        check({tag, " busy"}, EW'(Busy), EW'(0));
        check({tag, " hilo"}, EW'({1'b0, Hi, Lo}), exp_after);
        repeat (40) @(negedge Clk);
        check({tag, " no_done"}, EW'(done_cnt - d0), EW'(0));
        check({tag, " hilo_kept"}, EW'({1'b0, Hi, Lo}), exp_after);
    endtask

    initial begin
        logic [DW-1:0] ra, rb;
        logic [1:0] rop;
        int d0;
        int cycles;

        idle_inputs();
        do_reset();
        check("rst hi", EW'(Hi), EW'(0));
        check("rst lo", EW'(Lo), EW'(0));
        check("rst busy", EW'(Busy), EW'(0));
        check("rst done", EW'(Done), EW'(0));
        check("rst dbz", EW'(DivByZero), EW'(0));

        write_hilo(1, 0, 32'h12345678);
        check("mthi hi", EW'(Hi), EW'(32'h12345678));
        check("mthi lo", EW'(Lo), EW'(0));
        write_hilo(1, 1, 32'hCAFEF00D);
        check("mthilo hi", EW'(Hi), EW'(32'hCAFEF00D));
        check("mthilo lo", EW'(Lo), EW'(32'hCAFEF00D));

        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB}, 0);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001}, 0);
        run_op("mult_negneg", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, {1'b0, 32'h0, 32'd30}, 0);
        run_op("divu", 2'b11, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14}, 0);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        run_op("div_negdvs", 2'b10, 32'd7, 32'hFFFFFFFE, {1'b0, 32'd1, 32'hFFFFFFFD}, 0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h0, 32'h80000000}, 0);
        run_op("div_zero", 2'b10, 32'd55, 32'd0, {1'b1, 32'd55, 32'hFFFFFFFF}, 0);
        run_op("divu_zero", 2'b11, 32'hFFFFFFF0, 32'd0, {1'b1, 32'hFFFFFFF0, 32'hFFFFFFFF}, 0);
        run_op("flush_fix", 2'b01, 32'd6, 32'd9, {1'b0, 32'd0, 32'd54}, 1);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            rop = 2'($urandom_range(0, 3));
            if (i == 5) rb = 32'd0;
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 0);
        end

        abort_test("reset_abort", 1, EW'(0));
        abort_test("flush_abort", 0, {1'b0, 32'hAAAA0000, 32'hAAAA0000});

        // Start with a simultaneous MTLO drops the write; Start/MTHI/MTLO while busy are ignored.
        write_hilo(0, 1, 32'h00001111);
        d0 = done_cnt;
        Start = 1; Op = 2'b11; A = 32'd100; B = 32'd7;
        WriteLo = 1; WriteData = 32'hDEADBEEF;
        @(negedge Clk);
        Start = 0; WriteLo = 0;
        check("start_wr lo", EW'(Lo), EW'(32'h00001111));
        repeat (4) @(negedge Clk);
        Start = 1; Op = 2'b01; A = 32'd3; B = 32'd3;
        WriteHi = 1; WriteLo = 1; WriteData = 32'h55555555;
        @(negedge Clk);
        idle_inputs();
        check("busy_wr hi", EW'(Hi), EW'(32'hAAAA0000));
        check("busy_wr lo", EW'(Lo), EW'(32'h00001111));
        cycles = 0;
        while (!Done && cycles < 40) begin cycles++; @(negedge Clk); end
        check("busy_start done_seen", EW'(Done), EW'(1));
        repeat (45) @(negedge Clk);
        check("busy_start done_once", EW'(done_cnt - d0), EW'(1));
        check("busy_start hi", EW'(Hi), EW'(32'd2));
        check("busy_start lo", EW'(Lo), EW'(32'd14));
        check("busy_start idle", EW'(Busy), EW'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
